// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for a 4-digit, common-anode 7-segment display.
// A prescaler steps a 2-bit digit select every SCAN_DIV cycles. Each digit
// slot opens with BLANK_CYC cycles of all anodes off to suppress ghosting.
// New display data is captured into a shadow register on load. The shadow is
// committed only at the end of slot 3, so a frame never mixes old and new
// digits.
//
// Parameters:
//   SCAN_DIV  - clk cycles per digit slot (>= 2)
//   BLANK_CYC - cycles of anode blanking at the start of each slot
//               (0 .. SCAN_DIV-1)
//
// Optional feature (macro SEG7_LEADING_ZERO_BLANK_EN):
//   Digits above the most significant nonzero digit are blanked. Digit 0 is
//   always shown. When the macro is undefined all four digits are driven.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous reset, active-high
//   load     in   capture value/dp_in this cycle
//   value    in   [15:0] digit3..digit0 nibbles
//   dp_in    in   [3:0] decimal point per digit, 1 = on
//   upd_done out  one-cycle pulse after the shadow is committed to the display
//   pending  out  a captured value is waiting for commit
//   an       out  [3:0] anode enables, active-low, an[i] = digit i
//   seg      out  [6:0] segment cathodes, active-low, seg[0]=a .. seg[6]=g
//   dp_n     out  decimal-point cathode, active-low
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
   parameter int unsigned SCAN_DIV  = 100000,
   parameter int unsigned BLANK_CYC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   output logic        upd_done,
   output logic        pending,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp_n
);

   localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    sel_q, sel_d;
   logic [15:0]   disp_q, disp_d;
   logic [3:0]    dp_reg_q, dp_reg_d;
   logic [19:0]   shadow_q, shadow_d;
   logic          pending_q, pending_d;
   logic          upd_done_q, upd_done_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_n_q, dp_n_d;

   logic          tick;
   logic          blank;
   logic          commit;
   logic [3:0]    nibble;

   assign tick   = (cnt_q == CW'(SCAN_DIV - 1));
   assign blank  = (32'(cnt_q) < BLANK_CYC);
   assign commit = tick && (sel_q == 2'd3) && (pending_q || load);
   assign nibble = disp_q[{sel_q, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   // Index of the most significant digit to show; digit 0 always counts.
   logic [1:0] msd;
   always_comb begin
      msd = 2'd0;
      if (disp_q[15:12] != 4'h0)     msd = 2'd3;
      else if (disp_q[11:8] != 4'h0) msd = 2'd2;
      else if (disp_q[7:4] != 4'h0)  msd = 2'd1;
   end
`endif

   always_comb begin
      cnt_d      = tick ? '0 : cnt_q + CW'(1);
      sel_d      = tick ? sel_q + 2'd1 : sel_q;
      shadow_d   = load ? {dp_in, value} : shadow_q;
      disp_d     = disp_q;
      dp_reg_d   = dp_reg_q;
      pending_d  = pending_q;
      upd_done_d = commit;

      if (commit) begin
         // Same-cycle load bypasses the shadow so it is not lost.
         {dp_reg_d, disp_d} = load ? {dp_in, value} : shadow_q;
         pending_d          = 1'b0;
      end else if (load) begin
         pending_d = 1'b1;
      end

      an_d = 4'b1111;
      if (!blank) an_d = ~(4'b0001 << sel_q);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (sel_q > msd) an_d = 4'b1111;
`endif

      dp_n_d = ~dp_reg_q[sel_q];

      unique case (nibble)
         4'h0: seg_d = 7'h40;
         4'h1: seg_d = 7'h79;
         4'h2: seg_d = 7'h24;
         4'h3: seg_d = 7'h30;
         4'h4: seg_d = 7'h19;
         4'h5: seg_d = 7'h12;
         4'h6: seg_d = 7'h02;
         4'h7: seg_d = 7'h78;
         4'h8: seg_d = 7'h00;
         4'h9: seg_d = 7'h10;
         4'hA: seg_d = 7'h08;
         4'hB: seg_d = 7'h03;
         4'hC: seg_d = 7'h46;
         4'hD: seg_d = 7'h21;
         4'hE: seg_d = 7'h06;
         default: seg_d = 7'h0E;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         sel_q      <= 2'd0;
         disp_q     <= 16'h0000;
         dp_reg_q   <= 4'h0;
         shadow_q   <= 20'h00000;
         pending_q  <= 1'b0;
         upd_done_q <= 1'b0;
         an_q       <= 4'b1111;
         seg_q      <= 7'b1111111;
         dp_n_q     <= 1'b1;
      end else begin
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         disp_q     <= disp_d;
         dp_reg_q   <= dp_reg_d;
         shadow_q   <= shadow_d;
         pending_q  <= pending_d;
         upd_done_q <= upd_done_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         dp_n_q     <= dp_n_d;
      end
   end

   assign upd_done = upd_done_q;
   assign pending  = pending_q;
   assign an       = an_q;
   assign seg      = seg_q;
   assign dp_n     = dp_n_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

   localparam int SD = 4;
   localparam int BL = 1;
   localparam int FRAME = 4 * SD;

   logic        clk = 1'b0;
   logic        rst, load;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic        upd_done, pending;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp_n;

   seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BL)) dut (
      .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
      .upd_done(upd_done), .pending(pending), .an(an), .seg(seg), .dp_n(dp_n)
   );

   always #5 clk = ~clk;

   logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference model: time since reset, committed data, pending shadow.
   int          k;
   logic [15:0] m_disp;
   logic [3:0]  m_dp;
   logic [15:0] m_sh_val;
   logic [3:0]  m_sh_dp;
   bit          m_pend;

   int vectors = 0;
   int miscompares = 0;
   int upd_seen = 0;

   task automatic cyc(input logic r, input logic ld, input logic [15:0] v, input logic [3:0] d);
      int cnt, sel, top;
      logic [3:0] e_an, nib;
      logic [6:0] e_seg;
      logic e_dpn, e_upd, e_pend;
      bit do_commit;
      rst = r; load = ld; value = v; dp_in = d;
      @(posedge clk);
      #1;
      if (r) begin
         e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1; e_upd = 1'b0;
         k = 0; m_disp = 0; m_dp = 0; m_sh_val = 0; m_sh_dp = 0; m_pend = 0;
      end else begin
         cnt = k % SD;
         sel = (k / SD) % 4;
         nib = 4'((m_disp >> (4 * sel)) & 16'hF);
         e_an = (cnt < BL) ? 4'hF : ~(4'(1) << sel);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
         top = 0;
         for (int i = 0; i < 4; i++) if (((m_disp >> (4 * i)) & 16'hF) != 0) top = i;
         if (sel > top) e_an = 4'hF;
`else
         top = 3;
`endif
         e_seg = font[nib];
         e_dpn = ~m_dp[sel];
         do_commit = (k % FRAME == FRAME - 1) && (m_pend || ld);
         if (ld) begin m_sh_val = v; m_sh_dp = d; end
         if (do_commit) begin
            m_disp = m_sh_val; m_dp = m_sh_dp; m_pend = 0;
         end else if (ld) m_pend = 1;
         e_upd = do_commit;
         k++;
      end
      e_pend = m_pend;
      vectors++;
      if (upd_done === 1'b1) upd_seen++;
      assert (an === e_an) else begin miscompares++; $error("FAIL an: got %b expected %b (k=%0d)", an, e_an, k); end
      assert (seg === e_seg) else begin miscompares++; $error("FAIL seg: got %h expected %h (k=%0d)", seg, e_seg, k); end
      assert (dp_n === e_dpn) else begin miscompares++; $error("FAIL dp_n: got %b expected %b (k=%0d)", dp_n, e_dpn, k); end
      assert (upd_done === e_upd) else begin miscompares++; $error("FAIL upd_done: got %b expected %b (k=%0d)", upd_done, e_upd, k); end
      assert (pending === e_pend) else begin miscompares++; $error("FAIL pending: got %b expected %b (k=%0d)", pending, e_pend, k); end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, 4'h0);
   endtask

   task automatic align(input int phase);
      for (int i = 0; i < FRAME && (k % FRAME) != phase; i++) cyc(1'b0, 1'b0, 16'h0, 4'h0);
   endtask

   int ups;

   initial begin
      rst = 1'b1; load = 1'b0; value = 16'h0; dp_in = 4'h0;
      k = 0; m_disp = 0; m_dp = 0; m_sh_val = 0; m_sh_dp = 0; m_pend = 0;

      // Reset for two cycles, then free-running blank display.
      cyc(1'b1, 1'b0, 16'h0, 4'h0);
      cyc(1'b1, 1'b0, 16'h0, 4'h0);
      idle(2 * FRAME);

      // Load mid-slot 1, committed at the next frame boundary.
      align(5);
      ups = upd_seen;
      cyc(1'b0, 1'b1, 16'h1A3F, 4'b0010);
      idle(2 * FRAME);
      assert (upd_seen - ups == 1) else begin miscompares++; $error("FAIL upd_count_1A3F: got %0d expected 1", upd_seen - ups); end
      vectors++;

      // Last load wins within a frame.
      align(2);
      ups = upd_seen;
      cyc(1'b0, 1'b1, 16'h1111, 4'h0);
      idle(3);
      cyc(1'b0, 1'b1, 16'h2222, 4'h0);
      idle(2 * FRAME);
      assert (upd_seen - ups == 1) else begin miscompares++; $error("FAIL upd_count_2222: got %0d expected 1", upd_seen - ups); end
      vectors++;

      // Load exactly on the commit cycle (bypass).
      align(FRAME - 1);
      cyc(1'b0, 1'b1, 16'h8888, 4'hF);
      idle(2 * FRAME);

      // Leading-zero patterns (also exercised without the feature).
      align(7);
      cyc(1'b0, 1'b1, 16'h0050, 4'h0);
      idle(2 * FRAME);
      cyc(1'b0, 1'b1, 16'h0000, 4'h0);
      idle(2 * FRAME);

      // Randomized loads.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0)
            cyc(1'b0, 1'b1, 16'($urandom), 4'($urandom));
         else
            cyc(1'b0, 1'b0, 16'h0, 4'h0);
      end

      // Reset with a load pending: pending load is discarded.
      align(6);
      cyc(1'b0, 1'b1, 16'hBEEF, 4'h5);
      ups = upd_seen;
      cyc(1'b1, 1'b0, 16'h0, 4'h0);
      idle(2 * FRAME);
      assert (upd_seen == ups) else begin miscompares++; $error("FAIL upd_after_reset: got %0d expected 0", upd_seen - ups); end
      vectors++;

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 5) == 0)
            cyc(1'b0, 1'b1, 16'($urandom), 4'($urandom));
         else
            cyc(1'b0, 1'b0, 16'h0, 4'h0);
      end
      idle(2 * FRAME);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
